// File: rtl/vxv_pkg.sv
// Shared definitions for the vector-x-vector datapath: default widths, padding
// arithmetic and the streaming FSM state type.
package vxv_pkg;

  localparam int VXV_ELEMENT_WIDTH = 32;
  localparam int VXV_NO_OF_UNITS   = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Zero elements appended so the vector fills a whole number of lane chunks.
  function automatic int calc_additional(input int n, input int units);
    return (units - (n % units)) % units;
  endfunction

  function automatic int calc_total(input int n, input int units);
    return n + calc_additional(n, units);
  endfunction

  function automatic int calc_chunks(input int n, input int units);
    return calc_total(n, units) / units;
  endfunction

endpackage

// File: rtl/vxv_slot_mem.sv
// Slot storage for the vector bank: registered write of a zero-padded vector,
// combinational selection of one lane-wide chunk of a slot.
module vxv_slot_mem
  import vxv_pkg::*;
#(
  parameter int element_width = VXV_ELEMENT_WIDTH,
  parameter int n_elems       = 9,
  parameter int no_of_units   = VXV_NO_OF_UNITS,
  parameter int depth         = 4,
  parameter int addr_width    = 2,
  parameter int chunk_width   = 2
) (
  input  logic                               clk_i,
  input  logic                               wr_en_i,
  input  logic [addr_width-1:0]              wr_addr_i,
  input  logic [element_width*n_elems-1:0]   wr_data_i,
  input  logic [addr_width-1:0]              rd_addr_i,
  input  logic [chunk_width-1:0]             rd_chunk_i,
  output logic [element_width*no_of_units-1:0] rd_data_o
);

  localparam int TOTAL   = calc_total(n_elems, no_of_units);
  localparam int ROW_W   = element_width * TOTAL;
  localparam int CHUNK_W = element_width * no_of_units;

  logic [ROW_W-1:0] mem_q [depth];
  logic [ROW_W-1:0] padded;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] shifted;
  logic [31:0]      shamt;

  always_comb begin
    padded = '0;
    padded[ROW_W-1 -: element_width*n_elems] = wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= padded;
    end
  end

  // A same-cycle write to the slot being read is forwarded so a start sees the new vector.
  always_comb begin
    row       = (wr_en_i && (wr_addr_i == rd_addr_i)) ? padded : mem_q[rd_addr_i];
    shamt     = 32'(rd_chunk_i) * 32'(CHUNK_W);
    shifted   = row << shamt;
    rd_data_o = shifted[ROW_W-1 -: CHUNK_W];
  end

endmodule

// File: rtl/vxv_vector_bank.sv
// Multi-slot second-vector store: holds depth padded vectors and streams a
// selected one to the multiplier lanes, MS chunk first, under valid/ready.
module vxv_vector_bank
  import vxv_pkg::*;
#(
  parameter int element_width                   = VXV_ELEMENT_WIDTH,
  parameter int number_of_equations_per_cluster = 9,
  parameter int no_of_units                     = VXV_NO_OF_UNITS,
  parameter int depth                           = 4,
  parameter int slot_addr_width                 = 2,
  localparam int CHUNKS = calc_chunks(number_of_equations_per_cluster, no_of_units),
  localparam int IDX_W  = $clog2(CHUNKS) + 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  wr_valid,
  output logic                                                  wr_ready,
  input  logic [slot_addr_width-1:0]                            wr_addr,
  input  logic [element_width*number_of_equations_per_cluster-1:0] wr_data,
  input  logic                                                  clear,
  input  logic                                                  start_valid,
  output logic                                                  start_ready,
  input  logic [slot_addr_width-1:0]                            start_addr,
  output logic                                                  start_err,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [element_width*no_of_units-1:0]                  out_data,
  output logic [IDX_W-1:0]                                      out_index,
  output logic                                                  out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_e                           state_q, state_d;
  logic [slot_addr_width-1:0]       slot_q, slot_d;
  logic [depth-1:0]                 slot_valid_q, slot_valid_d;
  logic                             out_valid_q, out_valid_d;
  logic [element_width*no_of_units-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]                 out_index_q, out_index_d;
  logic                             out_last_q, out_last_d;
  logic                             start_err_q, start_err_d;

  logic                             mem_wr_en;
  logic                             start_hit;
  logic [slot_addr_width-1:0]       rd_addr;
  logic [IDX_W-1:0]                 rd_chunk;
  logic [element_width*no_of_units-1:0] rd_data;

  assign wr_ready    = !((state_q == STREAM) && (wr_addr == slot_q));
  // clear wins over a write, so the array keeps pre-clear contents for a same-cycle start.
  assign mem_wr_en   = wr_valid && wr_ready && !clear;
  assign start_hit   = slot_valid_q[start_addr] || (mem_wr_en && (wr_addr == start_addr));
  assign start_ready = (state_q == IDLE);

  always_comb begin
    rd_addr  = slot_q;
    rd_chunk = (out_index_q == LAST_IDX) ? out_index_q : out_index_q + IDX_W'(1);
    if (state_q == IDLE) begin
      rd_addr  = start_addr;
      rd_chunk = '0;
    end
  end

  vxv_slot_mem #(
    .element_width(element_width),
    .n_elems      (number_of_equations_per_cluster),
    .no_of_units  (no_of_units),
    .depth        (depth),
    .addr_width   (slot_addr_width),
    .chunk_width  (IDX_W)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_chunk_i(rd_chunk),
    .rd_data_o (rd_data)
  );

  always_comb begin
    slot_valid_d = slot_valid_q;
    if (mem_wr_en) begin
      slot_valid_d[wr_addr] = 1'b1;
    end
    if (clear) begin
      slot_valid_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    start_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          if (start_hit) begin
            state_d     = STREAM;
            slot_d      = start_addr;
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
            out_index_d = '0;
            out_last_d  = (CHUNKS == 1);
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (clear || (out_ready && out_last_q)) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_index_d = '0;
          out_last_d  = 1'b0;
        end else if (out_ready) begin
          out_data_d  = rd_data;
          out_index_d = out_index_q + IDX_W'(1);
          out_last_d  = ((out_index_q + IDX_W'(1)) == LAST_IDX);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      slot_valid_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
      start_err_q  <= start_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign start_err = start_err_q;

endmodule
